mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one physical memory port between two requesters: instruction-fetch (i_*) and data load/store (d_*).
- Lets the multicycle CPU control, and a later split fetch/data path or cache, drive one memory model.
- Latches the winning request into registers, holds it stable downstream until mem_resp, then routes the response back to the owner.
- Round-robin arbitration, so neither requester starves.

Parameters:
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits; byte-enable width is DATA_W/8
- WAIT_LIMIT, 255, watchdog limit on mem_resp wait cycles; 0 disables the watchdog

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- i_read  in  1  fetch read request; held until i_resp
- i_address  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetch read data
- i_resp  out  1  fetch complete, one-cycle pulse
- d_read  in  1  data read request; held until d_resp
- d_write  in  1  data write request; held until d_resp
- d_address  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_byte_enable  in  DATA_W/8  store byte mask
- d_rdata  out  DATA_W  load data
- d_resp  out  1  data access complete, one-cycle pulse
- mem_read  out  1  downstream read strobe
- mem_write  out  1  downstream write strobe
- mem_address  out  ADDR_W  downstream address
- mem_wdata  out  DATA_W  downstream write data
- mem_byte_enable  out  DATA_W/8  downstream byte mask
- mem_rdata  in  DATA_W  downstream read data
- mem_resp  in  1  downstream completion
- timeout  out  1  sticky watchdog error flag

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, last_grant=GNT_I, wait_cnt=0, timeout=0.
- Reset values, registered request outputs: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=4'b1111.
- While rst is high, i_resp and d_resp are forced to 0.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration:
  - d_req = d_read|d_write; i_req = i_read.
  - Only one request pending: grant it.
  - Both pending: grant the one not equal to last_grant.
  - On grant, register address, wdata, byte_enable and strobes into the mem_* outputs; set last_grant; move to BUSY_x.
  - Fetch grant uses mem_byte_enable=4'b1111 and mem_write=0.
- Latency: request sampled in IDLE at cycle N; mem_* request valid from cycle N+1. Minimum request-to-resp latency is 2 cycles.
- BUSY_x: mem_* outputs stay constant regardless of input changes.
  - When mem_resp=1, combinationally assert the owner's resp, drive owner_rdata=mem_rdata, and clear mem_read/mem_write at that edge.
  - Next state is IDLE, a one-cycle bubble that gives the requester time to drop its request.
- Non-owner outputs: resp=0 at all times; rdata is don't-care (drive mem_rdata to both).
- mem_resp arriving in IDLE is ignored; no resp is generated.
- Requester dropping its request mid-transaction is illegal. The arbiter still completes the access and pulses resp.
- d_read and d_write both high: treated as a write; d_rdata is undefined.
- Watchdog:
  - wait_cnt resets to 0 on each grant and increments each BUSY cycle without mem_resp.
  - Saturates at WAIT_LIMIT; reaching it sets timeout, which is sticky until rst.
  - The transaction is not aborted.
- Reset mid-transaction: state returns to IDLE and strobes drop at that edge. A mem_resp in the reset cycle is not forwarded; a late mem_resp arriving in IDLE is ignored.

Decomposition:
- Package arb_types holds:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D}
  - arb_grant_t enum {GNT_I, GNT_D}
- Default-width constants stay in rv32i_types.
- A single sub-module, mem_req_reg, is natural: a load-enabled register bundle for address/wdata/byte_enable/read/write with synchronous clear.

Test Plan:
- Fetch only: i_read=1, i_address=0x60, memory responds after 3 cycles with 0x00A00093 -> mem_read=1 from cycle 1; i_resp pulses once with i_rdata=0x00A00093; d_resp stays 0.
- Store only: d_write=1, d_address=0x104, d_wdata=0xDEADBEEF, be=4'b1100 -> mem_write=1 with identical address/data/mask held until mem_resp; d_resp pulses one cycle.
- Contention after reset: i_read and d_read asserted together -> d granted first (last_grant=GNT_I after reset), then i after the bubble; a third simultaneous pair is granted d again.
- Stability: change d_address from 0x200 to 0x300 while BUSY_D -> mem_address remains 0x200 until mem_resp.
- Reset mid-transaction: rst for 1 cycle during BUSY_I, with mem_resp=1 in the cycle after -> mem_read=0 after the rst edge, i_resp never pulses.
- Watchdog: WAIT_LIMIT=4, hold mem_resp=0 -> timeout=1 after 4 BUSY cycles and stays 1 after a later mem_resp until rst.

Source files
------------

// File: rtl/arb_types.sv
// Shared types for the fetch/data memory port arbiter.
package arb_types;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } arb_grant_t;

endpackage

// File: rtl/mem_req_reg.sv
// Registered downstream request bundle; load wins over strobe clear.
module mem_req_reg #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                stb_clr,
  input  logic                read_d,
  input  logic                write_d,
  input  logic [ADDR_W-1:0]   address_d,
  input  logic [DATA_W-1:0]   wdata_d,
  input  logic [DATA_W/8-1:0] byte_enable_d,
  output logic                read,
  output logic                write,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] byte_enable
);

  always_ff @(posedge clk) begin
    if (rst) begin
      read        <= 1'b0;
      write       <= 1'b0;
      address     <= '0;
      wdata       <= '0;
      byte_enable <= '1;
    end else if (load) begin
      read        <= read_d;
      write       <= write_d;
      address     <= address_d;
      wdata       <= wdata_d;
      byte_enable <= byte_enable_d;
    end else if (stb_clr) begin
      read  <= 1'b0;
      write <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data.
module mem_port_arbiter
  import arb_types::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_address,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_resp,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byte_enable,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_resp,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_byte_enable,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp,
  output logic                timeout
);

  localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT);

  arb_state_t state_q, state_d;
  arb_grant_t last_q;
  logic [CW-1:0] wait_q;
  logic [CW-1:0] wait_inc;
  logic grant_i, grant_d, done;
  logic busy, stall, cnt_en;
  logic i_req, d_req;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req && (!d_req || last_q == GNT_D)) begin
          grant_i = 1'b1;
          state_d = BUSY_I;
        end else if (d_req) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_resp) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = state_q != IDLE;
  assign stall    = busy && !mem_resp;
  assign cnt_en   = stall && (wait_q != LIM);
  assign wait_inc = wait_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GNT_I;
      wait_q  <= '0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_i) last_q <= GNT_I;
      if (grant_d) last_q <= GNT_D;
      if (grant_i || grant_d) begin
        wait_q <= '0;
      end else if (cnt_en) begin
        wait_q <= wait_inc;
      end
      if (WAIT_LIMIT != 0 && cnt_en && wait_inc == LIM)
        timeout <= 1'b1;
    end
  end

  // Simultaneous d_read/d_write is issued as a write.
  mem_req_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_req (
    .clk          (clk),
    .rst          (rst),
    .load         (grant_i | grant_d),
    .stb_clr      (done),
    .read_d       (grant_i | (d_read & ~d_write)),
    .write_d      (grant_d & d_write),
    .address_d    (grant_i ? i_address : d_address),
    .wdata_d      (grant_i ? '0 : d_wdata),
    .byte_enable_d(grant_i ? '1 : d_byte_enable),
    .read         (mem_read),
    .write        (mem_write),
    .address      (mem_address),
    .wdata        (mem_wdata),
    .byte_enable  (mem_byte_enable)
  );

  assign i_resp  = !rst && state_q == BUSY_I && mem_resp;
  assign d_resp  = !rst && state_q == BUSY_D && mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic [3:0]  d_byte_enable;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        timeout;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  req_t req_q[$];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .WAIT_LIMIT(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_read         (i_read),
    .i_address      (i_address),
    .i_rdata        (i_rdata),
    .i_resp         (i_resp),
    .d_read         (d_read),
    .d_write        (d_write),
    .d_address      (d_address),
    .d_wdata        (d_wdata),
    .d_byte_enable  (d_byte_enable),
    .d_rdata        (d_rdata),
    .d_resp         (d_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp),
    .timeout        (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be);
    req_t e;
    e.rd = rd;
    e.wr = wr;
    e.addr = a;
    e.wdata = wd;
    e.be = be;
    req_q.push_back(e);
  endtask

  // Caller drives the request; grant is expected at the very next edge.
  task automatic serve(input bit is_d, input int lat, input logic [31:0] rd);
    req_t e;
    e = req_q.pop_front();
    step();
    chk("req_read", 32'(mem_read), 32'(e.rd));
    chk("req_write", 32'(mem_write), 32'(e.wr));
    chk("req_addr", mem_address, e.addr);
    chk("req_be", 32'(mem_byte_enable), 32'(e.be));
    if (e.wr) chk("req_wdata", mem_wdata, e.wdata);
    if (is_d) begin
      d_address = d_address ^ 32'h100;
      d_wdata   = ~d_wdata;
    end else begin
      i_address = i_address ^ 32'h100;
    end
    for (int k = 1; k < lat; k++) begin
      step();
      chk("hold_addr", mem_address, e.addr);
      chk("hold_strobe", 32'({mem_read, mem_write}), 32'({e.rd, e.wr}));
      chk("wait_iresp", 32'(i_resp), 32'd0);
      chk("wait_dresp", 32'(d_resp), 32'd0);
    end
    mem_resp  = 1'b1;
    mem_rdata = rd;
    #1;
    chk("owner_resp", 32'(is_d ? d_resp : i_resp), 32'd1);
    chk("other_resp", 32'(is_d ? i_resp : d_resp), 32'd0);
    if (e.rd) chk("owner_rdata", is_d ? d_rdata : i_rdata, rd);
    step();
    mem_resp = 1'b0;
    if (is_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    #1;
    chk("strobe_clr", 32'({mem_read, mem_write}), 32'd0);
    chk("resp_pulse", 32'({i_resp, d_resp}), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    chk("rst_iresp", 32'(i_resp), 32'd0);
    chk("rst_dresp", 32'(d_resp), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL tb_time_limit: observed=expired expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_read = 1'b0;
    i_address = '0;
    d_read = 1'b0;
    d_write = 1'b0;
    d_address = '0;
    d_wdata = '0;
    d_byte_enable = '0;
    mem_rdata = '0;
    mem_resp = 1'b0;
    do_reset();
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(mem_byte_enable), 32'hF);
    chk("rst_timeout", 32'(timeout), 32'd0);

    // contention: d first after reset, then i, then d again
    i_read = 1'b1;
    i_address = 32'h40;
    d_read = 1'b1;
    d_address = 32'h44;
    push(1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
    push(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    d_byte_enable = 4'hF;
    serve(1'b1, 2, 32'h1111_0044);
    serve(1'b0, 2, 32'h2222_0040);
    i_read = 1'b1;
    i_address = 32'h48;
    d_read = 1'b1;
    d_address = 32'h4C;
    d_byte_enable = 4'h3;
    push(1'b1, 1'b0, 32'h4C, 32'h0, 4'h3);
    push(1'b1, 1'b0, 32'h48, 32'h0, 4'hF);
    serve(1'b1, 2, 32'h3333_004C);
    serve(1'b0, 2, 32'h4444_0048);

    // fetch only
    i_read = 1'b1;
    i_address = 32'h60;
    push(1'b1, 1'b0, 32'h60, 32'h0, 4'hF);
    serve(1'b0, 3, 32'h00A0_0093);

    // store only
    d_write = 1'b1;
    d_address = 32'h104;
    d_wdata = 32'hDEAD_BEEF;
    d_byte_enable = 4'b1100;
    push(1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF, 4'b1100);
    serve(1'b1, 3, 32'h0);

    // stability: address flips to 0x300 mid-transaction
    d_read = 1'b1;
    d_address = 32'h200;
    d_byte_enable = 4'hF;
    push(1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
    serve(1'b1, 4, 32'hCAFE_0200);
    chk("addr_input_moved", d_address, 32'h300);

    // read+write together is a write
    d_read = 1'b1;
    d_write = 1'b1;
    d_address = 32'h88;
    d_wdata = 32'h1234_5678;
    d_byte_enable = 4'b0110;
    push(1'b0, 1'b1, 32'h88, 32'h1234_5678, 4'b0110);
    serve(1'b1, 2, 32'h0);
    chk("no_timeout_yet", 32'(timeout), 32'd0);

    // stray mem_resp in IDLE
    mem_resp = 1'b1;
    #1;
    chk("idle_iresp", 32'(i_resp), 32'd0);
    chk("idle_dresp", 32'(d_resp), 32'd0);
    step();
    mem_resp = 1'b0;
    chk("idle_no_req", 32'({mem_read, mem_write}), 32'd0);

    // reset during BUSY_I
    i_read = 1'b1;
    i_address = 32'h80;
    step();
    chk("rmid_grant", 32'(mem_read), 32'd1);
    step();
    rst = 1'b1;
    i_read = 1'b0;
    mem_resp = 1'b1;
    mem_rdata = 32'hBAD0_0080;
    #1;
    chk("rmid_rst_iresp", 32'(i_resp), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rmid_strobe", 32'(mem_read), 32'd0);
    chk("rmid_late_iresp", 32'(i_resp), 32'd0);
    step();
    mem_resp = 1'b0;
    chk("rmid_idle", 32'(mem_read), 32'd0);
    chk("rmid_iresp2", 32'(i_resp), 32'd0);

    // watchdog with WAIT_LIMIT=4
    d_write = 1'b1;
    d_address = 32'h500;
    d_wdata = 32'h5555_AAAA;
    d_byte_enable = 4'hF;
    step();
    chk("wd_grant", 32'(mem_write), 32'd1);
    chk("wd_t0", 32'(timeout), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("wd_early", 32'(timeout), 32'd0);
    end
    step();
    chk("wd_fire", 32'(timeout), 32'd1);
    step();
    chk("wd_still_busy", 32'(mem_write), 32'd1);
    mem_resp = 1'b1;
    #1;
    chk("wd_late_dresp", 32'(d_resp), 32'd1);
    step();
    mem_resp = 1'b0;
    d_write = 1'b0;
    chk("wd_sticky1", 32'(timeout), 32'd1);
    step();
    step();
    chk("wd_sticky2", 32'(timeout), 32'd1);
    do_reset();
    chk("wd_cleared", 32'(timeout), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
